fpga_itrng_feeder: RTL

- Parametrised successor to the FPGA internal-TRNG path.
- Software pushes entropy words over the realtime register block; the block buffers them and unpacks each word into DATA_W-bit beats.
- Beats go to Caliptra's itrng_data/itrng_valid, throttled by a programmable divisor.
- Adds a replay mode that recirculates the buffered entropy indefinitely, plus overflow and underflow accounting.

---
 rtl/fpga_itrng_feeder_if.sv | 29 ++
 rtl/fpga_itrng_feeder.sv | 98 +++++++++
 2 files changed

// File: rtl/fpga_itrng_feeder_if.sv
// fpga_itrng_feeder_if: software entropy write port, throttle control and Caliptra itrng beat side
interface fpga_itrng_feeder_if #(
  parameter int WORD_W = 32,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 64,
  parameter int DIV_W  = 32,
  parameter int UCNT_W = 16
);
  logic                     wr_en;
  logic [WORD_W-1:0]        wr_data;
  logic                     replay_en;
  logic [DIV_W-1:0]         divisor;
  logic                     etrng_req;
  logic [DATA_W-1:0]        itrng_data;
  logic                     itrng_valid;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic [UCNT_W-1:0]        underflow_cnt;
  modport master (
    output wr_en, wr_data, replay_en, divisor, etrng_req,
    input  itrng_data, itrng_valid, full, empty, level, overflow, underflow_cnt
  );
  modport slave (
    input  wr_en, wr_data, replay_en, divisor, etrng_req,
    output itrng_data, itrng_valid, full, empty, level, overflow, underflow_cnt
  );
endinterface

// File: rtl/fpga_itrng_feeder.sv
// fpga_itrng_feeder: buffers software entropy words and unpacks them into throttled itrng beats
module fpga_itrng_feeder #(
  parameter int WORD_W = 32,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 64,
  parameter int DIV_W  = 32,
  parameter int UCNT_W = 16
) (
  input logic core_clk,
  input logic rst_b,
  input logic sw_reset,
  fpga_itrng_feeder_if.slave bus
);
  localparam int BEATS = WORD_W / DATA_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {UNLOADED, FETCH, LOADED} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic [WORD_W-1:0] sreg;
  logic [BW-1:0]     beat_idx;
  logic [DIV_W-1:0]  cnt;
  logic [UCNT_W-1:0] ucnt;
  logic [DATA_W-1:0] data;
  logic              valid, ovf, starved, replay_q;
  logic              full, empty, eligible, beat, last_beat, pop, push_rp, push_sw, push;
  assign full      = level == (AW+1)'(DEPTH);
  assign empty     = level == '0;
  assign eligible  = cnt == '0 && bus.etrng_req;
  assign beat      = eligible && state == LOADED;
  assign last_beat = beat && beat_idx == BW'(BEATS-1);
  assign pop       = !empty && (state == UNLOADED || last_beat);
  // replay recirculation follows the registered mode so a toggle only affects later pops
  assign push_rp   = pop && replay_q;
  assign push_sw   = bus.wr_en && !bus.replay_en && !full && !push_rp;
  assign push      = push_sw || push_rp;
  always_comb begin
    state_n = state;
    state_n = state == FETCH ? LOADED : pop ? FETCH : last_beat ? UNLOADED : state;
  end
  always_ff @(posedge core_clk)
    if (push && !sw_reset) mem[wr_ptr] <= push_rp ? mem[rd_ptr] : bus.wr_data;
  always_ff @(posedge core_clk or negedge rst_b)
    if (!rst_b) begin
      state    <= UNLOADED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sreg     <= '0;
      beat_idx <= '0;
      cnt      <= '0;
      ucnt     <= '0;
      data     <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      starved  <= 1'b0;
      replay_q <= 1'b0;
    end else if (sw_reset) begin
      state    <= UNLOADED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sreg     <= '0;
      beat_idx <= '0;
      cnt      <= '0;
      ucnt     <= '0;
      data     <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      starved  <= 1'b0;
      replay_q <= 1'b0;
    end else begin
      state    <= state_n;
      replay_q <= bus.replay_en;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) sreg <= mem[rd_ptr];
      level    <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (bus.wr_en && full && !bus.replay_en) ovf <= 1'b1;
      valid    <= beat;
      if (beat) data <= DATA_W'(sreg >> (DATA_W * int'(beat_idx)));
      beat_idx <= state == FETCH ? '0 : beat ? beat_idx + 1'b1 : beat_idx;
      cnt      <= beat ? bus.divisor : cnt != '0 ? cnt - 1'b1 : cnt;
      // a starvation episode counts once, on its first eligible cycle
      if (eligible && state != LOADED) starved <= 1'b1;
      else if (beat) starved <= 1'b0;
      if (eligible && state != LOADED && !starved && ucnt != '1) ucnt <= ucnt + 1'b1;
    end
  assign bus.itrng_data    = data;
  assign bus.itrng_valid   = valid;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.level         = level;
  assign bus.overflow      = ovf;
  assign bus.underflow_cnt = ucnt;
endmodule
